// File: rtl/uart_frame_parser.sv
// uart_frame_parser: turns the UART receiver's byte strobe into checked
// command frames (0x55 0xAA, LEN, payload, checksum). The payload is buffered
// and, if the checksum matches, replayed downstream as a valid/ready byte
// stream with a last-byte marker.
module uart_frame_parser #(
    parameter int CLK_FRE     = 50,
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = CLK_FRE * 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic [7:0] frame_len,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       overrun
);

    localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HUNT0,
        ST_HUNT1,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_OUT
    } state_e;

    state_e        state_q,      state_d;
    logic          prev_valid_q, prev_valid_d;
    logic [7:0]    sum_q,        sum_d;
    logic [7:0]    wr_idx_q,     wr_idx_d;
    logic [7:0]    rd_idx_q,     rd_idx_d;
    logic [7:0]    frame_len_q,  frame_len_d;
    logic [TW-1:0] tmo_q,        tmo_d;
    logic          m_valid_q,    m_valid_d;
    logic [7:0]    m_data_q,     m_data_d;
    logic          m_last_q,     m_last_d;
    logic          frame_ok_q,   frame_ok_d;
    logic          frame_err_q,  frame_err_d;
    logic          overrun_q,    overrun_d;

    logic [7:0]    pay_mem_q [MAX_LEN];
    logic          mem_we;
    logic          byte_stb;
    logic          tmo_active;
    logic [7:0]    rd_nxt;
    logic [7:0]    mem_cur;
    logic [7:0]    mem_nxt;

    // The receiver holds in_valid for several cycles; only its rising edge is a byte.
    assign byte_stb   = in_valid & ~prev_valid_q;
    assign tmo_active = (state_q == ST_HUNT1) || (state_q == ST_LEN) ||
                        (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    assign rd_nxt     = rd_idx_q + 8'd1;
    assign mem_cur    = pay_mem_q[rd_idx_q[AW-1:0]];
    assign mem_nxt    = pay_mem_q[rd_nxt[AW-1:0]];

    // Next-state logic: frame parsing, timeout, and output-stream sequencing.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can infer a latch.
        state_d      = state_q;
        prev_valid_d = in_valid;
        sum_d        = sum_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        frame_len_d  = frame_len_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        mem_we       = 1'b0;

        // A byte always clears the timer, so it wins over a same-cycle expiry.
        if (byte_stb || !tmo_active) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            ST_HUNT0: begin
                if (byte_stb && in_data == 8'h55) state_d = ST_HUNT1;
            end
            ST_HUNT1: begin
                if (byte_stb) begin
                    if (in_data == 8'hAA)      state_d = ST_LEN;
                    else if (in_data != 8'h55) state_d = ST_HUNT0;
                end
            end
            ST_LEN: begin
                if (byte_stb) begin
                    if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT0;
                    end else begin
                        frame_len_d = in_data;
                        sum_d       = in_data;
                        wr_idx_d    = 8'd0;
                        state_d     = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_stb) begin
                    mem_we   = 1'b1;
                    sum_d    = sum_q + in_data;
                    wr_idx_d = wr_idx_q + 8'd1;
                    if (wr_idx_q == frame_len_q - 8'd1) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (byte_stb) begin
                    if (in_data == sum_q) begin
                        frame_ok_d = 1'b1;
                        rd_idx_d   = 8'd0;
                        state_d    = ST_OUT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT0;
                    end
                end
            end
            ST_OUT: begin
                // Bytes arriving while the buffer drains are dropped, never parsed.
                overrun_d = byte_stb;
                if (!m_valid_q) begin
                    // First cycle after frame_ok: present byte 0.
                    m_valid_d = 1'b1;
                    m_data_d  = mem_cur;
                    m_last_d  = (rd_idx_q == frame_len_q - 8'd1);
                end else if (m_ready) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_data_d  = 8'd0;
                        m_last_d  = 1'b0;
                        rd_idx_d  = 8'd0;
                        state_d   = ST_HUNT0;
                    end else begin
                        rd_idx_d = rd_nxt;
                        m_data_d = mem_nxt;
                        m_last_d = (rd_nxt == frame_len_q - 8'd1);
                    end
                end
            end
            default: state_d = ST_HUNT0;
        endcase

        // Inter-byte timeout abandons a partial frame.
        if (!byte_stb && tmo_active && tmo_q == TMO_LAST) begin
            frame_err_d = 1'b1;
            state_d     = ST_HUNT0;
            tmo_d       = '0;
        end
    end

    // State and registered outputs; reset discards any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT0;
            prev_valid_q <= 1'b0;
            sum_q        <= 8'd0;
            wr_idx_q     <= 8'd0;
            rd_idx_q     <= 8'd0;
            frame_len_q  <= 8'd0;
            tmo_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= 8'd0;
            m_last_q     <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            prev_valid_q <= prev_valid_d;
            sum_q        <= sum_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            frame_len_q  <= frame_len_d;
            tmo_q        <= tmo_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Payload buffer write port.
    // NOTE: the buffer has no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (mem_we) pay_mem_q[wr_idx_q[AW-1:0]] <= in_data;
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign frame_len = frame_len_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: hand-built frames with hand-computed
// checksums, a negedge monitor collecting the output stream and pulses.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic [7:0] frame_len;
    logic       frame_ok;
    logic       frame_err;
    logic       overrun;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    uart_frame_parser #(
        .CLK_FRE    (50),
        .MAX_LEN    (16),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .frame_len(frame_len),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor state
    int         ok_cnt = 0, err_cnt = 0, ovr_cnt = 0, valid_cnt = 0;
    int         stall_viol = 0, rise_viol = 0, err_cyc = 0;
    logic [7:0] rx_data [$];
    logic       rx_last [$];
    int         rx_cyc  [$];
    logic [7:0] rx_len  [$];
    logic       p_stall = 1'b0, p_ok = 1'b0, p_valid = 1'b0, p_last = 1'b0;
    logic [7:0] p_data = 8'd0;

    // Sample just after the negedge, when the inputs for the next posedge are settled.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            p_stall = 1'b0; p_ok = 1'b0; p_valid = 1'b0;
        end else begin
            if (frame_ok)  ok_cnt++;
            if (frame_err) begin err_cnt++; err_cyc = cyc; end
            if (overrun)   ovr_cnt++;
            if (m_valid)   valid_cnt++;
            if (p_stall && (!m_valid || m_data !== p_data || m_last !== p_last)) stall_viol++;
            if (m_valid && !p_valid && !p_ok) rise_viol++;
            if (m_valid && m_ready) begin
                rx_data.push_back(m_data);
                rx_last.push_back(m_last);
                rx_cyc.push_back(cyc);
                rx_len.push_back(frame_len);
            end
            p_stall = m_valid && !m_ready;
            p_data  = m_data;
            p_last  = m_last;
            p_ok    = frame_ok;
            p_valid = m_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         last_drive_cyc = 0;
    logic [7:0] tx_q [$];

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        in_data        = b;
        in_valid       = 1'b1;
        last_drive_cyc = cyc;
        repeat (hold) @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_tx(input int hold);
        foreach (tx_q[i]) send_byte(tx_q[i], hold);
        @(negedge clk);
    endtask

    task automatic wait_rx(input string tag, input int target);
        for (int i = 0; i < 200; i++) begin
            if (rx_data.size() >= target) break;
            @(negedge clk);
            #2;
        end
        check(tag, rx_data.size(), target);
        repeat (3) @(negedge clk);
    endtask

    int ok0, err0, ovr0, val0, rx0;

    task automatic mark();
        ok0 = ok_cnt; err0 = err_cnt; ovr0 = ovr_cnt; val0 = valid_cnt; rx0 = rx_data.size();
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_outs", {m_data, m_last, frame_len, frame_ok, frame_err, overrun}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good 3-byte frame, m_ready held high
        mark();
        tx_q = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_tx(2);
        wait_rx("t1_drain", rx0 + 3);
        check("t1_ok", ok_cnt - ok0, 1);
        check("t1_err", err_cnt - err0, 0);
        if (rx_data.size() >= rx0 + 3) begin
            check("t1_bytes", {rx_data[rx0], rx_data[rx0+1], rx_data[rx0+2]}, 24'h112233);
            check("t1_last", {rx_last[rx0], rx_last[rx0+1], rx_last[rx0+2]}, 3'b001);
            check("t1_consec", {rx_cyc[rx0+1] - rx_cyc[rx0], rx_cyc[rx0+2] - rx_cyc[rx0+1]}, {32'd1, 32'd1});
            check("t1_len", rx_len[rx0], 3);
        end

        // Bad checksum, then the good frame again
        mark();
        tx_q = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
        send_tx(2);
        repeat (10) @(negedge clk);
        check("t2_err", err_cnt - err0, 1);
        check("t2_no_ok", ok_cnt - ok0, 0);
        check("t2_no_valid", valid_cnt - val0, 0);
        mark();
        tx_q = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_tx(2);
        wait_rx("t2_drain", rx0 + 3);
        check("t2_ok_after", ok_cnt - ok0, 1);
        if (rx_data.size() >= rx0 + 3)
            check("t2_bytes", {rx_data[rx0], rx_data[rx0+1], rx_data[rx0+2]}, 24'h112233);

        // LEN boundaries and junk before a header
        mark();
        tx_q = {8'h55, 8'hAA, 8'h00};
        send_tx(2);
        tx_q = {8'h55, 8'hAA, 8'h11};
        send_tx(2);
        repeat (3) @(negedge clk);
        check("t3_len_err", err_cnt - err0, 2);
        mark();
        tx_q = {8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        send_tx(2);
        wait_rx("t3_drain", rx0 + 1);
        check("t3_ok", ok_cnt - ok0, 1);
        check("t3_err", err_cnt - err0, 0);
        if (rx_data.size() >= rx0 + 1) check("t3_byte", {rx_data[rx0], rx_last[rx0]}, {8'h7E, 1'b1});

        // Long in_valid level and a stalling sink
        mark();
        m_ready = 1'b0;
        tx_q = {8'h55, 8'hAA, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
        send_tx(40);
        repeat (3) @(negedge clk);
        check("t4_stalled", {m_valid, m_data}, {1'b1, 8'h01});
        for (int i = 0; i < 40 && rx_data.size() < rx0 + 4; i++) begin
            @(negedge clk);
            m_ready = (i % 2 == 0);
        end
        @(negedge clk);
        m_ready = 1'b1;
        wait_rx("t4_drain", rx0 + 4);
        check("t4_ok", ok_cnt - ok0, 1);
        if (rx_data.size() >= rx0 + 4) begin
            check("t4_bytes", {rx_data[rx0], rx_data[rx0+1], rx_data[rx0+2], rx_data[rx0+3]}, 32'h01020304);
            check("t4_last", {rx_last[rx0], rx_last[rx0+1], rx_last[rx0+2], rx_last[rx0+3]}, 4'b0001);
        end
        check("t4_stable", stall_viol, 0);

        // Inter-byte timeout
        mark();
        tx_q = {8'h55, 8'hAA, 8'h02, 8'hA0};
        send_tx(2);
        repeat (150) @(negedge clk);
        check("t5_tmo_err", err_cnt - err0, 1);
        check("t5_tmo_cycle", err_cyc - last_drive_cyc, 101);
        mark();
        tx_q = {8'h55, 8'hAA, 8'h01, 8'h05, 8'h06};
        send_tx(2);
        wait_rx("t5_drain", rx0 + 1);
        check("t5_ok", ok_cnt - ok0, 1);
        if (rx_data.size() >= rx0 + 1) check("t5_byte", {rx_data[rx0], rx_last[rx0]}, {8'h05, 1'b1});

        // Overrun during a stalled drain
        mark();
        m_ready = 1'b0;
        tx_q = {8'h55, 8'hAA, 8'h02, 8'hC3, 8'h3C, 8'h01};
        send_tx(2);
        send_byte(8'h55, 2);
        send_byte(8'hAA, 2);
        repeat (3) @(negedge clk);
        check("t6_overrun", ovr_cnt - ovr0, 2);
        check("t6_held", {m_valid, m_data, m_last}, {1'b1, 8'hC3, 1'b0});
        m_ready = 1'b1;
        wait_rx("t6_drain", rx0 + 2);
        if (rx_data.size() >= rx0 + 2)
            check("t6_bytes", {rx_data[rx0], rx_data[rx0+1], rx_last[rx0+1]}, {8'hC3, 8'h3C, 1'b1});
        mark();
        tx_q = {8'h01, 8'h7E, 8'h7F, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        send_tx(2);
        wait_rx("t6_resync", rx0 + 1);
        check("t6_one_frame", ok_cnt - ok0, 1);

        // Reset mid-payload
        mark();
        tx_q = {8'h55, 8'hAA, 8'h04, 8'h01, 8'h02};
        send_tx(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t7_rst_outs", {m_valid, m_data, m_last, frame_len, frame_ok, frame_err, overrun}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mark();
        tx_q = {8'h03, 8'h04, 8'h0E};
        send_tx(2);
        repeat (3) @(negedge clk);
        check("t7_stale", {ok_cnt - ok0, err_cnt - err0}, 0);
        tx_q = {8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        send_tx(2);
        wait_rx("t7_drain", rx0 + 1);
        check("t7_ok", ok_cnt - ok0, 1);

        check("rise_after_ok", rise_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
